// File: rtl/sfb_axi_rd_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// sfb_axi_rd_arbiter_pkg
//  Definitions shared by the two-master AXI3 read arbiter:
//   - source tags written into ARID[7] and decoded from RID[7]
//   - bit index of that source tag
//   - width of the per-master outstanding-burst counters
//   - AR FSM state encoding
// ----------------------------------------------------------------------------
package sfb_axi_rd_arbiter_pkg;

  // Source tag values: framebuffer pixel fetch and auxiliary reader
  localparam logic SFB_SRC_FB  = 1'b0;
  localparam logic SFB_SRC_AUX = 1'b1;

  // ARID/RID bit that carries the source tag
  localparam int SFB_ARID_TAG_BIT = 7;

  // Outstanding counters hold 0..15
  localparam int SFB_OUTST_W = 4;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } sfb_ar_state_e;

endpackage

// File: rtl/sfb_axi_rd_arbiter.sv
// ----------------------------------------------------------------------------
// sfb_axi_rd_arbiter
//  Two-master AXI3 read arbiter in front of the single FPGA-to-SDRAM read
//  port. m0 is the framebuffer pixel fetch, m1 the overlay/blitter source.
//  AR requests are serialised (at most one every two clocks), the downstream
//  ARID carries the source in bit 7, R beats are routed back by RID[7], and
//  each master is limited to MAX_OUTST bursts in flight.
//
//  state | meaning
//  ------+---------------------------------------------------------------
//  IDLE  | arbitrate; grant pulses arready and captures the AR fields
//  ISSUE | out_arvalid_o held with stable fields until out_arready_i
//
// Ports
//  clk_i, rst_i                      clock, synchronous active-high reset
//  m{0,1}_ar*_i / m{0,1}_arready_o   upstream AR channels
//  m{0,1}_r*_o  / m{0,1}_rready_i    upstream R channels (routed)
//  m0_urgent_i                       m0 line buffer low: strict m0 priority
//  out_ar*_o / out_arready_i         downstream AR channel
//  out_r*_i  / out_rready_o          downstream R channel
//  m{0,1}_outst_o                    outstanding burst counts (status)
// ----------------------------------------------------------------------------
module sfb_axi_rd_arbiter
  import sfb_axi_rd_arbiter_pkg::*;
#(
  parameter int AXI_DW    = 256,
  parameter int MAX_OUTST = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,

  input  logic [31:0]       m0_araddr_i,
  input  logic [3:0]        m0_arlen_i,
  input  logic [2:0]        m0_arsize_i,
  input  logic [1:0]        m0_arburst_i,
  input  logic [7:0]        m0_arid_i,
  input  logic              m0_arvalid_i,
  output logic              m0_arready_o,
  output logic [AXI_DW-1:0] m0_rdata_o,
  output logic [1:0]        m0_rresp_o,
  output logic              m0_rlast_o,
  output logic [7:0]        m0_rid_o,
  output logic              m0_rvalid_o,
  input  logic              m0_rready_i,
  input  logic              m0_urgent_i,

  input  logic [31:0]       m1_araddr_i,
  input  logic [3:0]        m1_arlen_i,
  input  logic [2:0]        m1_arsize_i,
  input  logic [1:0]        m1_arburst_i,
  input  logic [7:0]        m1_arid_i,
  input  logic              m1_arvalid_i,
  output logic              m1_arready_o,
  output logic [AXI_DW-1:0] m1_rdata_o,
  output logic [1:0]        m1_rresp_o,
  output logic              m1_rlast_o,
  output logic [7:0]        m1_rid_o,
  output logic              m1_rvalid_o,
  input  logic              m1_rready_i,

  output logic [31:0]       out_araddr_o,
  output logic [3:0]        out_arlen_o,
  output logic [2:0]        out_arsize_o,
  output logic [1:0]        out_arburst_o,
  output logic [7:0]        out_arid_o,
  output logic              out_arvalid_o,
  input  logic              out_arready_i,
  output logic [1:0]        out_arlock_o,
  output logic [2:0]        out_arprot_o,
  output logic [3:0]        out_arcache_o,

  input  logic [AXI_DW-1:0] out_rdata_i,
  input  logic [1:0]        out_rresp_i,
  input  logic              out_rlast_i,
  input  logic [7:0]        out_rid_i,
  input  logic              out_rvalid_i,
  output logic              out_rready_o,

  output logic [3:0]        m0_outst_o,
  output logic [3:0]        m1_outst_o
);

  localparam logic [SFB_OUTST_W-1:0] LP_MAX = SFB_OUTST_W'(MAX_OUTST);

  sfb_ar_state_e r_state;
  sfb_ar_state_e w_state_nxt;

  logic        r_rr_last;
  logic [31:0] r_araddr;
  logic [3:0]  r_arlen;
  logic [2:0]  r_arsize;
  logic [1:0]  r_arburst;
  logic [7:0]  r_arid;

  logic [1:0]             w_arvalid;
  logic [1:0]             w_elig;
  logic                   w_gnt;
  logic                   w_gnt_src;
  logic [SFB_OUTST_W-1:0] w_outst [2];

  logic [31:0] w_sel_addr;
  logic [3:0]  w_sel_len;
  logic [2:0]  w_sel_size;
  logic [1:0]  w_sel_burst;
  logic [7:0]  w_sel_id;

  logic        w_rsrc;
  logic        w_unused;

  assign w_arvalid = {m1_arvalid_i, m0_arvalid_i};

  // --------------------------------------------------------------------------
  // AR FSM: grant is only ever raised in IDLE, which gives the one-AR-per-two
  // clocks throughput and keeps upstream arready a single-cycle pulse.
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_gnt       = 1'b0;
    w_gnt_src   = SFB_SRC_FB;
    case (r_state)
      ST_IDLE: begin
        if (w_elig[0] && m0_urgent_i) begin
          w_gnt     = 1'b1;
          w_gnt_src = SFB_SRC_FB;
        end else if (w_elig[0] && w_elig[1]) begin
          // Both contend: the one that did not win last time goes next
          w_gnt     = 1'b1;
          w_gnt_src = ~r_rr_last;
        end else if (w_elig[0]) begin
          w_gnt     = 1'b1;
          w_gnt_src = SFB_SRC_FB;
        end else if (w_elig[1]) begin
          w_gnt     = 1'b1;
          w_gnt_src = SFB_SRC_AUX;
        end
        if (w_gnt) begin
          w_state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (out_arready_i) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  assign m0_arready_o = w_gnt & (w_gnt_src == SFB_SRC_FB);
  assign m1_arready_o = w_gnt & (w_gnt_src == SFB_SRC_AUX);

  assign w_sel_addr  = (w_gnt_src == SFB_SRC_AUX) ? m1_araddr_i  : m0_araddr_i;
  assign w_sel_len   = (w_gnt_src == SFB_SRC_AUX) ? m1_arlen_i   : m0_arlen_i;
  assign w_sel_size  = (w_gnt_src == SFB_SRC_AUX) ? m1_arsize_i  : m0_arsize_i;
  assign w_sel_burst = (w_gnt_src == SFB_SRC_AUX) ? m1_arburst_i : m0_arburst_i;
  assign w_sel_id    = (w_gnt_src == SFB_SRC_AUX) ? m1_arid_i    : m0_arid_i;

  // Captured AR and round-robin history; upstream ARID[7] is replaced by the
  // source tag so the returning RID can be routed.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rr_last <= SFB_SRC_AUX;
      r_araddr  <= '0;
      r_arlen   <= '0;
      r_arsize  <= '0;
      r_arburst <= '0;
      r_arid    <= '0;
    end else if (w_gnt) begin
      r_rr_last <= w_gnt_src;
      r_araddr  <= w_sel_addr;
      r_arlen   <= w_sel_len;
      r_arsize  <= w_sel_size;
      r_arburst <= w_sel_burst;
      r_arid    <= {w_gnt_src, w_sel_id[SFB_ARID_TAG_BIT-1:0]};
    end
  end

  assign out_arvalid_o = (r_state == ST_ISSUE);
  assign out_araddr_o  = r_araddr;
  assign out_arlen_o   = r_arlen;
  assign out_arsize_o  = r_arsize;
  assign out_arburst_o = r_arburst;
  assign out_arid_o    = r_arid;
  assign out_arlock_o  = 2'b00;
  assign out_arprot_o  = 3'b000;
  assign out_arcache_o = 4'b0000;

  // --------------------------------------------------------------------------
  // R path: purely combinational routing on RID[7]
  // --------------------------------------------------------------------------
  assign w_rsrc = out_rid_i[SFB_ARID_TAG_BIT];

  assign out_rready_o = (w_rsrc == SFB_SRC_AUX) ? m1_rready_i : m0_rready_i;

  assign m0_rvalid_o = out_rvalid_i & (w_rsrc == SFB_SRC_FB);
  assign m1_rvalid_o = out_rvalid_i & (w_rsrc == SFB_SRC_AUX);

  assign m0_rdata_o  = out_rdata_i;
  assign m1_rdata_o  = out_rdata_i;
  assign m0_rresp_o  = out_rresp_i;
  assign m1_rresp_o  = out_rresp_i;
  assign m0_rlast_o  = out_rlast_i;
  assign m1_rlast_o  = out_rlast_i;
  assign m0_rid_o    = {1'b0, out_rid_i[SFB_ARID_TAG_BIT-1:0]};
  assign m1_rid_o    = {1'b0, out_rid_i[SFB_ARID_TAG_BIT-1:0]};

  // --------------------------------------------------------------------------
  // Per-master outstanding burst counters
  // --------------------------------------------------------------------------
  for (genvar g = 0; g < 2; g++) begin : g_outst
    logic [SFB_OUTST_W-1:0] r_cnt;
    logic                   w_inc;
    logic                   w_hit;
    logic                   w_dec;

    assign w_inc = w_gnt & (w_gnt_src == 1'(g));
    assign w_hit = out_rvalid_i & out_rready_o & out_rlast_i & (w_rsrc == 1'(g));
    // A stray rlast at zero is routed but not counted, so the count cannot
    // wrap; when it coincides with a grant the two cancel.
    assign w_dec = w_hit & ((r_cnt != '0) | w_inc);

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        r_cnt <= '0;
      end else if (w_inc && !w_dec) begin
        r_cnt <= r_cnt + 1'b1;
      end else if (w_dec && !w_inc) begin
        r_cnt <= r_cnt - 1'b1;
      end
    end

    assign w_outst[g] = r_cnt;
    assign w_elig[g]  = w_arvalid[g] & (r_cnt < LP_MAX);
  end

  assign m0_outst_o = w_outst[0];
  assign m1_outst_o = w_outst[1];

  // Upstream ARID[7] is deliberately discarded
  assign w_unused = ^{m0_arid_i[SFB_ARID_TAG_BIT], m1_arid_i[SFB_ARID_TAG_BIT]};

endmodule

// File: tb/tb_sfb_axi_rd_arbiter.sv
module tb_sfb_axi_rd_arbiter;

  localparam int DW   = 256;
  localparam int MAXO = 4;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic [7:0]  id;
  } ar_t;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [1:0]    resp;
    logic          last;
    logic [7:0]    id;
  } r_t;

  logic clk_i = 1'b0;
  logic rst_i;

  logic [31:0] araddr  [2];
  logic [3:0]  arlen   [2];
  logic [2:0]  arsize  [2];
  logic [1:0]  arburst [2];
  logic [7:0]  arid    [2];
  logic        arvalid [2];
  logic        rready  [2];
  logic        m0_urgent;

  logic          m0_arready_o, m1_arready_o;
  logic [DW-1:0] m0_rdata_o, m1_rdata_o;
  logic [1:0]    m0_rresp_o, m1_rresp_o;
  logic          m0_rlast_o, m1_rlast_o;
  logic [7:0]    m0_rid_o, m1_rid_o;
  logic          m0_rvalid_o, m1_rvalid_o;
  logic [31:0]   out_araddr_o;
  logic [3:0]    out_arlen_o;
  logic [2:0]    out_arsize_o;
  logic [1:0]    out_arburst_o;
  logic [7:0]    out_arid_o;
  logic          out_arvalid_o;
  logic          out_arready_i;
  logic [1:0]    out_arlock_o;
  logic [2:0]    out_arprot_o;
  logic [3:0]    out_arcache_o;
  logic [DW-1:0] out_rdata_i;
  logic [1:0]    out_rresp_i;
  logic          out_rlast_i;
  logic [7:0]    out_rid_i;
  logic          out_rvalid_i;
  logic          out_rready_o;
  logic [3:0]    m0_outst_o, m1_outst_o;

  sfb_axi_rd_arbiter #(.AXI_DW(DW), .MAX_OUTST(MAXO)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .m0_araddr_i(araddr[0]), .m0_arlen_i(arlen[0]), .m0_arsize_i(arsize[0]),
    .m0_arburst_i(arburst[0]), .m0_arid_i(arid[0]), .m0_arvalid_i(arvalid[0]),
    .m0_arready_o(m0_arready_o), .m0_rdata_o(m0_rdata_o), .m0_rresp_o(m0_rresp_o),
    .m0_rlast_o(m0_rlast_o), .m0_rid_o(m0_rid_o), .m0_rvalid_o(m0_rvalid_o),
    .m0_rready_i(rready[0]), .m0_urgent_i(m0_urgent),
    .m1_araddr_i(araddr[1]), .m1_arlen_i(arlen[1]), .m1_arsize_i(arsize[1]),
    .m1_arburst_i(arburst[1]), .m1_arid_i(arid[1]), .m1_arvalid_i(arvalid[1]),
    .m1_arready_o(m1_arready_o), .m1_rdata_o(m1_rdata_o), .m1_rresp_o(m1_rresp_o),
    .m1_rlast_o(m1_rlast_o), .m1_rid_o(m1_rid_o), .m1_rvalid_o(m1_rvalid_o),
    .m1_rready_i(rready[1]),
    .out_araddr_o(out_araddr_o), .out_arlen_o(out_arlen_o), .out_arsize_o(out_arsize_o),
    .out_arburst_o(out_arburst_o), .out_arid_o(out_arid_o), .out_arvalid_o(out_arvalid_o),
    .out_arready_i(out_arready_i), .out_arlock_o(out_arlock_o), .out_arprot_o(out_arprot_o),
    .out_arcache_o(out_arcache_o),
    .out_rdata_i(out_rdata_i), .out_rresp_i(out_rresp_i), .out_rlast_i(out_rlast_i),
    .out_rid_i(out_rid_i), .out_rvalid_i(out_rvalid_i), .out_rready_o(out_rready_o),
    .m0_outst_o(m0_outst_o), .m1_outst_o(m1_outst_o)
  );

  always #5 clk_i = ~clk_i;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Scoreboard queues
  ar_t exp_ar [$];
  r_t  exp_r0 [$];
  r_t  exp_r1 [$];

  // Reference model: arbiter busy flag, last winner, outstanding counts
  logic mon_en   = 1'b0;
  logic mdl_busy = 1'b0;
  logic mdl_rr   = 1'b1;
  int   mdl_outst [2] = '{0, 0};

  // --------------------------------------------------------------------------
  // Monitor + model, evaluated mid-cycle when all inputs are settled
  // --------------------------------------------------------------------------
  always @(negedge clk_i) begin
    logic e0, e1, g, gs, rs, hit;
    ar_t  ga;
    r_t   gr;
    int   nv;
    if (mon_en) begin
      e0 = arvalid[0] && (mdl_outst[0] < MAXO);
      e1 = arvalid[1] && (mdl_outst[1] < MAXO);
      g  = !mdl_busy && (e0 || e1);
      if (e0 && m0_urgent)  gs = 1'b0;
      else if (e0 && e1)    gs = !mdl_rr;
      else if (e1)          gs = 1'b1;
      else                  gs = 1'b0;

      chk("m0_arready", m0_arready_o, g && !gs);
      chk("m1_arready", m1_arready_o, g && gs);
      chk("out_arvalid", out_arvalid_o, mdl_busy);
      chk("m0_outst", m0_outst_o, mdl_outst[0]);
      chk("m1_outst", m1_outst_o, mdl_outst[1]);

      if (out_arvalid_o && out_arready_i) begin
        ga = '{addr: out_araddr_o, len: out_arlen_o, size: out_arsize_o,
               burst: out_arburst_o, id: out_arid_o};
        n_tests++;
        if (exp_ar.size() == 0) begin
          n_fail++;
          $display("FAIL ar_unexpected: got %h expected none", ga);
        end else begin
          if (ga !== exp_ar[0]) begin
            n_fail++;
            $display("FAIL ar_fields: got %h expected %h", ga, exp_ar[0]);
          end
          void'(exp_ar.pop_front());
        end
        chk("ar_consts", {out_arlock_o, out_arprot_o, out_arcache_o}, 9'd0);
      end

      rs = out_rid_i[7];
      chk("m0_rvalid", m0_rvalid_o, out_rvalid_i && !rs);
      chk("m1_rvalid", m1_rvalid_o, out_rvalid_i && rs);
      if (out_rvalid_i) chk("out_rready", out_rready_o, rs ? rready[1] : rready[0]);

      if (m0_rvalid_o) begin
        gr = '{data: m0_rdata_o, resp: m0_rresp_o, last: m0_rlast_o, id: m0_rid_o};
        n_tests++;
        if (exp_r0.size() == 0) begin
          n_fail++;
          $display("FAIL r0_unexpected: got %h expected none", gr);
        end else begin
          if (gr !== exp_r0[0]) begin
            n_fail++;
            $display("FAIL r0_beat: got %h expected %h", gr, exp_r0[0]);
          end
          if (rready[0]) void'(exp_r0.pop_front());
        end
      end
      if (m1_rvalid_o) begin
        gr = '{data: m1_rdata_o, resp: m1_rresp_o, last: m1_rlast_o, id: m1_rid_o};
        n_tests++;
        if (exp_r1.size() == 0) begin
          n_fail++;
          $display("FAIL r1_unexpected: got %h expected none", gr);
        end else begin
          if (gr !== exp_r1[0]) begin
            n_fail++;
            $display("FAIL r1_beat: got %h expected %h", gr, exp_r1[0]);
          end
          if (rready[1]) void'(exp_r1.pop_front());
        end
      end

      // Advance model to the state after the coming clock edge
      if (rst_i) begin
        mdl_busy = 1'b0;
        mdl_rr   = 1'b1;
        mdl_outst = '{0, 0};
        exp_ar.delete();
        exp_r0.delete();
        exp_r1.delete();
      end else begin
        if (mdl_busy && out_arready_i) mdl_busy = 1'b0;
        hit = out_rvalid_i && out_rlast_i && (rs ? rready[1] : rready[0]);
        for (int x = 0; x < 2; x++) begin
          nv = mdl_outst[x] + ((g && (gs == 1'(x))) ? 1 : 0);
          if (hit && (rs == 1'(x)) && nv > 0) nv--;
          mdl_outst[x] = nv;
        end
        if (g) begin
          exp_ar.push_back('{addr: araddr[gs], len: arlen[gs], size: arsize[gs],
                             burst: arburst[gs], id: {gs, arid[gs][6:0]}});
          mdl_busy = 1'b1;
          mdl_rr   = gs;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus: masters, downstream slave, handshakes
  // --------------------------------------------------------------------------
  logic        auto_m, auto_hs, slave_en;
  int          p_req [2];
  int          p_arready, p_rready, p_rbeat, umode, len_max;
  logic [11:0] sq [$];
  int          beat;
  int          g_cnt [2];

  task automatic new_req(input int x);
    araddr[x]  = $urandom();
    arlen[x]   = 4'($urandom_range(len_max));
    arsize[x]  = 3'($urandom_range(7));
    arburst[x] = 2'($urandom_range(3));
    arid[x]    = 8'($urandom_range(255));
    arvalid[x] = 1'b1;
  endtask

  task automatic step();
    logic acc [2];
    logic ar_hs, r_hs, rst_s;
    logic [11:0] hs;
    r_t   e;
    @(negedge clk_i);
    rst_s  = rst_i;
    acc[0] = arvalid[0] && m0_arready_o;
    acc[1] = arvalid[1] && m1_arready_o;
    ar_hs  = out_arvalid_o && out_arready_i;
    hs     = {out_arid_o, out_arlen_o};
    r_hs   = out_rvalid_i && out_rready_o;
    @(posedge clk_i);
    #1;
    if (rst_s) return;
    if (ar_hs) sq.push_back(hs);
    for (int x = 0; x < 2; x++) begin
      if (acc[x]) begin
        arvalid[x] = 1'b0;
        g_cnt[x]++;
      end
      if (auto_m && !arvalid[x] && $urandom_range(99) < p_req[x]) new_req(x);
    end
    if (auto_hs) begin
      out_arready_i = ($urandom_range(99) < p_arready);
      rready[0]     = ($urandom_range(99) < p_rready);
      rready[1]     = ($urandom_range(99) < p_rready);
      if (umode == 2) m0_urgent = 1'($urandom_range(1));
      else            m0_urgent = 1'(umode);
    end
    if (slave_en) begin
      if (r_hs) begin
        if (out_rlast_i) begin
          void'(sq.pop_front());
          beat = 0;
        end else begin
          beat++;
        end
        out_rvalid_i = 1'b0;
      end
      if (!out_rvalid_i && sq.size() > 0 && $urandom_range(99) < p_rbeat) begin
        for (int i = 0; i < DW / 32; i++) out_rdata_i[i*32 +: 32] = $urandom();
        out_rresp_i  = 2'($urandom_range(3));
        out_rid_i    = sq[0][11:4];
        out_rlast_i  = (beat == int'(sq[0][3:0]));
        out_rvalid_i = 1'b1;
        e = '{data: out_rdata_i, resp: out_rresp_i, last: out_rlast_i,
              id: {1'b0, out_rid_i[6:0]}};
        if (out_rid_i[7]) exp_r1.push_back(e);
        else              exp_r0.push_back(e);
      end
    end
  endtask

  task automatic do_reset(input int n);
    rst_i        = 1'b1;
    arvalid[0]   = 1'b0;
    arvalid[1]   = 1'b0;
    out_rvalid_i = 1'b0;
    out_arready_i = 1'b0;
    sq.delete();
    beat = 0;
    repeat (n) step();
    rst_i = 1'b0;
  endtask

  task automatic wait_idle(input string nm, input int budget);
    int t = 0;
    auto_m = 1'b0; auto_hs = 1'b1; slave_en = 1'b1;
    p_arready = 100; p_rready = 100; p_rbeat = 100; umode = 0;
    while (t < budget && (m0_outst_o != 0 || m1_outst_o != 0 || out_arvalid_o ||
           arvalid[0] || arvalid[1] || sq.size() != 0 || out_rvalid_i)) begin
      step();
      t++;
    end
    if (t >= budget) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_timeout: got busy after %0d cycles expected idle", nm, t);
    end
  endtask

  initial begin
    rst_i = 1'b1;
    for (int x = 0; x < 2; x++) begin
      araddr[x] = '0; arlen[x] = '0; arsize[x] = '0; arburst[x] = '0;
      arid[x] = '0; arvalid[x] = 1'b0; rready[x] = 1'b0; p_req[x] = 0; g_cnt[x] = 0;
    end
    m0_urgent = 1'b0; out_arready_i = 1'b0;
    out_rdata_i = '0; out_rresp_i = '0; out_rlast_i = 1'b0; out_rid_i = '0; out_rvalid_i = 1'b0;
    auto_m = 1'b0; auto_hs = 1'b0; slave_en = 1'b0;
    p_arready = 0; p_rready = 0; p_rbeat = 0; umode = 0; len_max = 15; beat = 0;

    do_reset(3);
    mon_en = 1'b1;

    // Reset state
    chk("rst_arready", {m0_arready_o, m1_arready_o}, 2'b00);
    chk("rst_arvalid", out_arvalid_o, 1'b0);
    chk("rst_rvalid", {m0_rvalid_o, m1_rvalid_o}, 2'b00);
    chk("rst_outst", {m0_outst_o, m1_outst_o}, 8'h00);

    // 1: single m0 request, 16 beats, tag bit cleared, 1-clk latency
    araddr[0] = 32'h1E00_0000; arlen[0] = 4'd15; arsize[0] = 3'd5;
    arburst[0] = 2'd1; arid[0] = 8'hA3; arvalid[0] = 1'b1;
    step();
    chk("t1_granted", g_cnt[0], 1);
    chk("t1_arvalid", out_arvalid_o, 1'b1);
    chk("t1_arid", out_arid_o, 8'h23);
    chk("t1_araddr", out_araddr_o, 32'h1E00_0000);
    chk("t1_arlen", out_arlen_o, 4'd15);
    step();
    out_arready_i = 1'b1;
    step();
    wait_idle("t1", 200);

    // 5 + stray rlast: rid 0x81 held by m1, count already zero
    auto_hs = 1'b0; slave_en = 1'b0;
    rready[0] = 1'b1; rready[1] = 1'b0;
    for (int i = 0; i < DW / 32; i++) out_rdata_i[i*32 +: 32] = 32'hC0DE_0000 + i;
    out_rresp_i = 2'b10; out_rlast_i = 1'b1; out_rid_i = 8'h81; out_rvalid_i = 1'b1;
    exp_r1.push_back('{data: out_rdata_i, resp: 2'b10, last: 1'b1, id: 8'h01});
    #2;
    chk("t5_out_rready", out_rready_o, 1'b0);
    chk("t5_m0_rvalid", m0_rvalid_o, 1'b0);
    chk("t5_m1_rid", m1_rid_o, 8'h01);
    step();
    rready[1] = 1'b1;
    step();
    out_rvalid_i = 1'b0;
    step();
    chk("t5_no_underflow", m1_outst_o, 4'd0);

    // 2: both requesting, short bursts returned promptly -> strict alternation
    auto_m = 1'b1; auto_hs = 1'b1; slave_en = 1'b1;
    p_req[0] = 100; p_req[1] = 100; p_arready = 100; p_rready = 100; p_rbeat = 100;
    umode = 0; len_max = 0; g_cnt[0] = 0; g_cnt[1] = 0;
    repeat (40) step();
    chk("t2_balance", ((g_cnt[0] > g_cnt[1]) ? g_cnt[0] - g_cnt[1] : g_cnt[1] - g_cnt[0]) <= 1, 1'b1);
    chk("t2_both_served", (g_cnt[0] >= 8) && (g_cnt[1] >= 8), 1'b1);
    wait_idle("t2", 500);

    // 3: urgent m0 fills first, then m1 gets its slots
    auto_m = 1'b1; slave_en = 1'b0; umode = 1; len_max = 15;
    p_req[0] = 100; p_req[1] = 100;
    repeat (24) step();
    chk("t3_m0_full", m0_outst_o, 4'd4);
    chk("t3_m1_full", m1_outst_o, 4'd4);
    wait_idle("t3", 2000);

    // 4: no R returned -> 4 per master then stalled; one rlast frees a slot
    auto_m = 1'b1; slave_en = 1'b0; umode = 0; p_rready = 100;
    repeat (30) step();
    chk("t4_sat", {m0_outst_o, m1_outst_o}, 8'h44);
    slave_en = 1'b1; p_rbeat = 60; p_rready = 70;
    repeat (60) step();

    // Random mixed traffic
    p_req[0] = 60; p_req[1] = 60; p_arready = 60; p_rready = 70; p_rbeat = 70;
    umode = 2;
    repeat (3000) step();
    wait_idle("rand", 3000);

    // 6: reset while ISSUE is stalled
    auto_hs = 1'b0; slave_en = 1'b0;
    out_arready_i = 1'b0;
    araddr[1] = 32'h0000_4000; arlen[1] = 4'd3; arsize[1] = 3'd5;
    arburst[1] = 2'd1; arid[1] = 8'h11; arvalid[1] = 1'b1;
    step();
    step();
    chk("t6_issue", out_arvalid_o, 1'b1);
    do_reset(1);
    chk("t6_arvalid", out_arvalid_o, 1'b0);
    chk("t6_outst", m1_outst_o, 4'd0);

    // Traffic resumes after reset
    auto_m = 1'b1; auto_hs = 1'b1; slave_en = 1'b1;
    p_req[0] = 50; p_req[1] = 50; p_arready = 80; p_rready = 80; p_rbeat = 80;
    repeat (500) step();
    wait_idle("post_rst", 3000);
    chk("end_ar_queue", exp_ar.size(), 0);
    chk("end_r_queues", exp_r0.size() + exp_r1.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
